// File: rtl/ls74194_pkg.sv
// ============================================================================
// Module  : ls74194_pkg
// Brief   : Op encodings, ls74194 mode constants and FSM state type shared by
//           the ls74194 sequencer and its pin decoder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ls74194_pkg;

    localparam logic [2:0] OP_CLEAR = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_ROR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;

    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_SHR  = 2'b01;
    localparam logic [1:0] S_SHL  = 2'b10;
    localparam logic [1:0] S_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_multi(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
    endfunction

    function automatic logic op_is_reserved(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ls74194_pin_decode.sv
// ============================================================================
// Module  : ls74194_pin_decode
// Brief   : Combinational map from sequencer state and latched command to the
//           ls74194 control pins. Pins sit at idle values outside EXEC.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ls74194_pin_decode
    import ls74194_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] op,
    input  logic [3:0] data,
    input  logic       fill,
    input  logic       q_msb,
    input  logic       q_lsb,
    output logic       clr_n,
    output logic [1:0] s,
    output logic [3:0] p,
    output logic       sil,
    output logic       sir
);

    always_comb begin
        clr_n = 1'b1;
        s     = S_HOLD;
        p     = 4'h0;
        sil   = 1'b0;
        sir   = 1'b0;
        if (state == ST_EXEC) begin
            case (op)
                OP_CLEAR: clr_n = 1'b0;
                OP_LOAD: begin
                    s = S_LOAD;
                    p = data;
                end
                OP_SHR: begin
                    s   = S_SHR;
                    sir = fill;
                end
                OP_SHL: begin
                    s   = S_SHL;
                    sil = fill;
                end
                // rotates feed the outgoing bit straight back from the live q
                OP_ROR: begin
                    s   = S_SHR;
                    sir = q_lsb;
                end
                OP_ROL: begin
                    s   = S_SHL;
                    sil = q_msb;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ls74194_seq_ctrl.sv
// ============================================================================
// Module  : ls74194_seq_ctrl
// Brief   : Accepts one command over valid/ready, drives an ls74194 for the
//           required number of cycles and returns q with a done pulse.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ls74194_seq_ctrl
    import ls74194_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [3:0]       req_data,
    input  logic             req_fill,
    input  logic [CNT_W-1:0] req_count,
    output logic             sr_clear_n,
    output logic [1:0]       sr_s,
    output logic [3:0]       sr_p,
    output logic             sr_sil,
    output logic             sr_sir,
    input  logic [3:0]       sr_q,
    output logic             done,
    output logic [3:0]       result,
    output logic             err
);

    localparam logic [CNT_W:0] c_cnt_one = (CNT_W+1)'(1);

    state_t         r_state;
    logic [2:0]     r_op;
    logic [3:0]     r_data;
    logic           r_fill;
    logic [CNT_W:0] r_cnt;
    logic [3:0]     r_result;
    logic           w_dec_clr_n;

    // counter is one bit wider than req_count so a full 2^CNT_W shift fits
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_CLEAR;
            r_data   <= 4'h0;
            r_fill   <= 1'b0;
            r_cnt    <= '0;
            r_result <= 4'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_data  <= req_data;
                        r_fill  <= req_fill;
                        r_cnt   <= op_is_multi(req_op) ? ({1'b0, req_count} + c_cnt_one) : c_cnt_one;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_result <= sr_q;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    ls74194_pin_decode u_pin_decode (
        .state (r_state),
        .op    (r_op),
        .data  (r_data),
        .fill  (r_fill),
        .q_msb (sr_q[3]),
        .q_lsb (sr_q[0]),
        .clr_n (w_dec_clr_n),
        .s     (sr_s),
        .p     (sr_p),
        .sil   (sr_sil),
        .sir   (sr_sir)
    );

    assign sr_clear_n = clear_n & w_dec_clr_n;
    assign req_ready  = clear_n & (r_state == ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign err        = done & op_is_reserved(r_op);
    assign result     = r_result;

endmodule

`default_nettype wire

// File: tb/tb_ls74194_seq_ctrl.sv
// ============================================================================
// Module  : tb_ls74194_seq_ctrl
// Brief   : Directed and random command bench for ls74194_seq_ctrl driving a
//           behavioural ls74194, checked against an arithmetic model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ls74194_seq_ctrl;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_op = 3'd0;
    logic [3:0] req_data = 4'd0;
    logic       req_fill = 1'b0;
    logic [1:0] req_count = 2'd0;
    logic       sr_clear_n;
    logic [1:0] sr_s;
    logic [3:0] sr_p;
    logic       sr_sil;
    logic       sr_sir;
    logic [3:0] sr_q;
    logic       done;
    logic [3:0] result;
    logic       err;

    int checks = 0;
    int errors = 0;
    int m_q    = 0;
    int m_res  = 0;

    always #5 clk = ~clk;

    // behavioural ls74194 with asynchronous clear
    always_ff @(posedge clk or negedge sr_clear_n) begin
        if (!sr_clear_n) sr_q <= 4'h0;
        else begin
            case (sr_s)
                2'b01:   sr_q <= {sr_sir, sr_q[3:1]};
                2'b10:   sr_q <= {sr_q[2:0], sr_sil};
                2'b11:   sr_q <= sr_p;
                default: sr_q <= sr_q;
            endcase
        end
    end

    ls74194_seq_ctrl #(.CNT_W(2)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_data   (req_data),
        .req_fill   (req_fill),
        .req_count  (req_count),
        .sr_clear_n (sr_clear_n),
        .sr_s       (sr_s),
        .sr_p       (sr_p),
        .sr_sil     (sr_sil),
        .sr_sir     (sr_sir),
        .sr_q       (sr_q),
        .done       (done),
        .result     (result),
        .err        (err)
    );

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // reference: apply one command to the model register, return action count
    function automatic int model_apply(input int op, input int d, input int f, input int c);
        int n;
        n = 1;
        case (op)
            0: m_q = 0;
            1: m_q = d;
            2: begin n = c + 1; for (int i = 0; i < n; i++) m_q = (m_q >> 1) + 8 * f; end
            3: begin n = c + 1; for (int i = 0; i < n; i++) m_q = ((m_q * 2) % 16) + f; end
            4: begin n = c + 1; m_q = ((m_q >> (n % 4)) | (m_q << (4 - n % 4))) % 16; end
            5: begin n = c + 1; m_q = ((m_q << (n % 4)) | (m_q >> (4 - n % 4))) % 16; end
            default: ;
        endcase
        return n;
    endfunction

    task automatic send(input int op, input int d, input int f, input int c, input bit poke);
        int k, j, n, low, saw_sclr;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        check("ready_before_accept", int'(req_ready), 1);
        req_valid = 1'b1;
        req_op    = op[2:0];
        req_data  = d[3:0];
        req_fill  = f[0];
        req_count = c[1:0];
        n = model_apply(op, d, f, c);
        @(negedge clk);
        req_valid = 1'b0;
        j = 0; low = 0; saw_sclr = 0;
        while (!done && j < 20) begin
            if (!req_ready) low++;
            if (!sr_clear_n) saw_sclr++;
            if (poke && j == 0) begin
                req_valid = 1'b1; req_op = 3'b001; req_data = 4'hF;
            end
            @(negedge clk);
            req_valid = 1'b0;
            j++;
        end
        check("done_latency", j, n);
        check("err_flag", int'(err), (op >= 6) ? 1 : 0);
        check("ready_low_in_done", int'(req_ready), 0);
        check("ready_low_cycles", low + 1, n + 1);
        if (op == 0) check("sclr_cycles", saw_sclr, 1);
        m_res = m_q;
        @(negedge clk);
        check("result", int'(result), m_res);
        check("done_one_cycle", int'(done), 0);
        check("sr_q", int'(sr_q), m_q);
        check("ready_after", int'(req_ready), 1);
    endtask

    initial begin
        int hold_q;
        // reset state
        #2;
        check("rst_sclr", int'(sr_clear_n), 0);
        check("rst_ready", int'(req_ready), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_err", int'(err), 0);
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        #1;
        check("post_rst_sclr", int'(sr_clear_n), 1);
        check("post_rst_ready", int'(req_ready), 1);
        check("idle_s", int'(sr_s), 0);

        send(1, 4'b1010, 0, 0, 0);
        send(2, 0, 0, 0, 0);
        send(3, 0, 1, 1, 0);
        send(1, 4'b1001, 0, 0, 0);
        send(4, 0, 0, 0, 0);
        send(5, 0, 0, 3, 0);
        send(1, 4'b1111, 0, 0, 0);
        send(0, 0, 0, 0, 0);
        send(1, 4'b0101, 0, 0, 0);
        send(6, 0, 0, 2, 1);
        send(7, 3, 1, 3, 0);

        // reset mid-SHL, after the second shift
        send(1, 4'b1011, 0, 0, 0);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b011; req_fill = 1'b1; req_count = 2'd3;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_q_two_shifts", int'(sr_q), 4'b1111);
        clear_n = 1'b0;
        #1;
        check("mid_rst_q", int'(sr_q), 0);
        check("mid_rst_sclr", int'(sr_clear_n), 0);
        check("mid_rst_ready", int'(req_ready), 0);
        check("mid_rst_result", int'(result), 0);
        hold_q = 0;
        repeat (3) begin @(negedge clk); if (done) hold_q++; end
        clear_n = 1'b1;
        repeat (6) begin @(negedge clk); if (done) hold_q++; end
        check("mid_rst_no_done", hold_q, 0);
        check("mid_rst_idle_ready", int'(req_ready), 1);
        m_q = 0; m_res = 0;
        send(1, 4'b0110, 0, 0, 0);

        // random commands
        for (int r = 0; r < 40; r++) begin
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // sr_s must never leave hold while the controller is not executing
    always @(negedge clk) begin
        if (clear_n && req_ready && sr_s !== 2'b00) begin
            errors++;
            $error("FAIL idle_sr_s observed=%0d expected=0", sr_s);
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
